// File: rtl/reg_bank_arbiter.sv
// Two-requester round-robin write arbiter in front of a five-entry PWM/enable register bank.
// Optional macro SHADOW_COMMIT_EN: writes land in shadow registers and reach the outputs on commit.
module reg_bank_arbiter #(
  parameter logic [7:0] DUTY_RST     = 8'h00,
  parameter bit         PRIO_A_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_req,
  input  logic [6:0] a_addr,
  input  logic [7:0] a_data,
  output logic       a_ack,
  input  logic       b_req,
  input  logic [6:0] b_addr,
  input  logic [7:0] b_data,
  output logic       b_ack,
  input  logic       commit,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       err_addr
);

  localparam int DATA_W = 8;
  localparam int ADDR_W = 7;
  localparam int NREGS  = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2,
    ACK     = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_prio_a;
  logic                r_a_ack;
  logic                r_b_ack;
  logic                r_err;
  logic [ADDR_W-1:0]   r_addr_p0;
  logic [DATA_W-1:0]   r_data_p0;
  logic [DATA_W-1:0]   r_reg [NREGS];

  logic w_a_wins;
  logic w_any_req;
  logic w_mapped;
  logic w_wr;

  // Only one requester high: it wins outright; both high: the pointer decides.
  assign w_a_wins  = a_req & (~b_req | r_prio_a);
  assign w_any_req = a_req | b_req;
  assign w_mapped  = (r_addr_p0 < ADDR_W'(NREGS));
  assign w_wr      = ((r_state == GRANT_A) || (r_state == GRANT_B)) && w_mapped;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_prio_a <= PRIO_A_FIRST;
      r_a_ack  <= 1'b0;
      r_b_ack  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_a_ack <= 1'b0;
      r_b_ack <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            if (w_a_wins) begin
              r_state  <= GRANT_A;
              r_prio_a <= 1'b0;
            end else begin
              r_state  <= GRANT_B;
              r_prio_a <= 1'b1;
            end
          end
        end
        GRANT_A: begin
          r_state <= ACK;
          r_a_ack <= 1'b1;
          r_err   <= ~w_mapped;
        end
        GRANT_B: begin
          r_state <= ACK;
          r_b_ack <= 1'b1;
          r_err   <= ~w_mapped;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // p0: winner's address/data captured on the IDLE->GRANT edge, held through GRANT
  always_ff @(posedge clk) begin
    if (r_state == IDLE) begin
      r_addr_p0 <= w_a_wins ? a_addr : b_addr;
      r_data_p0 <= w_a_wins ? a_data : b_data;
    end
  end

`ifdef SHADOW_COMMIT_EN
  logic [DATA_W-1:0] r_shd [NREGS];

  // Commit copies the shadow as it stood before any write landing on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_reg[i] <= (i == NREGS - 1) ? DUTY_RST : '0;
        r_shd[i] <= (i == NREGS - 1) ? DUTY_RST : '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (commit) r_reg[i] <= r_shd[i];
        if (w_wr && (r_addr_p0 == ADDR_W'(i))) r_shd[i] <= r_data_p0;
      end
    end
  end
`else
  logic w_unused_commit;
  assign w_unused_commit = commit;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        r_reg[i] <= (i == NREGS - 1) ? DUTY_RST : '0;
    end else begin
      for (int i = 0; i < NREGS; i++)
        if (w_wr && (r_addr_p0 == ADDR_W'(i))) r_reg[i] <= r_data_p0;
    end
  end
`endif

  assign a_ack           = r_a_ack;
  assign b_ack           = r_b_ack;
  assign err_addr        = r_err;
  assign en_reg_out_7_0  = r_reg[0];
  assign en_reg_out_15_8 = r_reg[1];
  assign en_reg_pwm_7_0  = r_reg[2];
  assign en_reg_pwm_15_8 = r_reg[3];
  assign pwm_duty_cycle  = r_reg[4];

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed and randomized bench for reg_bank_arbiter with a transaction-level reference model.
module tb_reg_bank_arbiter;

`ifdef SHADOW_COMMIT_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       a_req, b_req, commit;
  logic [6:0] a_addr, b_addr;
  logic [7:0] a_data, b_data;
  logic       a_ack, b_ack, err_addr;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;

  int n_tests = 0;
  int n_fail  = 0;

  reg_bank_arbiter dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_ack(a_ack),
    .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_ack(b_ack),
    .commit(commit),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] regs_now();
    return {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle};
  endfunction

  task automatic do_reset();
    rst = 1'b1; a_req = 1'b0; b_req = 1'b0; commit = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [7:0] m_out [5];
  logic [7:0] m_shd [5];
  int         m_next_idle, m_ack_cycle;
  bit         m_ack_a, m_err, m_wr, m_a_next, prev_commit, win_a, exp_a, exp_b, exp_e;
  logic [6:0] m_addr;
  logic [7:0] m_data;
  logic [39:0] exp_regs;

  initial begin
    a_addr = '0; a_data = '0; b_addr = '0; b_data = '0;
    do_reset();

    // reset state
    check("rst_regs", regs_now(), 40'h0);
    check("rst_acks", {a_ack, b_ack, err_addr}, 3'b000);

    // single write from A to pwm_duty_cycle
    a_req = 1'b1; a_addr = 7'd4; a_data = 8'h80;
    tick();
    check("single_n1_ack", {a_ack, b_ack}, 2'b00);
    tick();
    check("single_duty", pwm_duty_cycle, SHADOW ? 8'h00 : 8'h80);
    check("single_acks", {a_ack, b_ack, err_addr}, 3'b100);
    a_req = 1'b0;
    tick();
    check("single_ack_pulse", {a_ack, b_ack}, 2'b00);

    // tie after reset: A first, B next idle
    do_reset();
    a_req = 1'b1; a_addr = 7'd0; a_data = 8'h0F;
    b_req = 1'b1; b_addr = 7'd0; b_data = 8'hF0;
    tick();
    tick();
    check("tie_a_ack", {a_ack, b_ack}, 2'b10);
    check("tie_reg_a", en_reg_out_7_0, SHADOW ? 8'h00 : 8'h0F);
    a_req = 1'b0;
    tick();
    tick();
    check("tie_b_wait", {a_ack, b_ack}, 2'b00);
    tick();
    check("tie_b_ack", {a_ack, b_ack}, 2'b01);
    check("tie_reg_b", en_reg_out_7_0, SHADOW ? 8'h00 : 8'hF0);
    b_req = 1'b0;
    tick();

    // unmapped address from B
    exp_regs = regs_now();
    b_req = 1'b1; b_addr = 7'd7; b_data = 8'hFF;
    tick();
    tick();
    check("unmap_ack_err", {a_ack, b_ack, err_addr}, 3'b011);
    check("unmap_regs", regs_now(), exp_regs);
    b_req = 1'b0;
    tick();
    check("unmap_err_pulse", err_addr, 1'b0);

    // reset during GRANT_A discards the write
    a_req = 1'b1; a_addr = 7'd2; a_data = 8'h55;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; a_req = 1'b0;
    check("rstmid_ack", {a_ack, b_ack}, 2'b00);
    check("rstmid_reg", en_reg_pwm_7_0, 8'h00);
    tick();
    check("rstmid_ack2", {a_ack, b_ack}, 2'b00);
    b_req = 1'b1; b_addr = 7'd3; b_data = 8'hA5;
    tick();
    tick();
    check("rstmid_idle_ack", {a_ack, b_ack}, 2'b01);
    check("rstmid_idle_reg", en_reg_pwm_15_8, SHADOW ? 8'h00 : 8'hA5);
    b_req = 1'b0;

    // commit behaviour on en_reg_out_15_8
    do_reset();
    a_req = 1'b1; a_addr = 7'd1; a_data = 8'h33;
    tick();
    check("commit_n1", en_reg_out_15_8, 8'h00);
    tick();
    check("commit_n2", en_reg_out_15_8, SHADOW ? 8'h00 : 8'h33);
    a_req = 1'b0;
    tick();
    tick();
    check("commit_n4", en_reg_out_15_8, SHADOW ? 8'h00 : 8'h33);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    check("commit_n5", en_reg_out_15_8, 8'h33);

    // randomized traffic against the transaction-level model
    do_reset();
    for (int i = 0; i < 5; i++) begin
      m_out[i] = (i == 4) ? 8'h00 : 8'h00;
      m_shd[i] = m_out[i];
    end
    m_next_idle = 0; m_ack_cycle = -1; m_wr = 1'b0; m_a_next = 1'b1; prev_commit = 1'b0;
    m_ack_a = 1'b0; m_err = 1'b0; m_addr = '0; m_data = '0;
    for (int t = 0; t < 1500; t++) begin
      if (SHADOW && prev_commit)
        for (int i = 0; i < 5; i++) m_out[i] = m_shd[i];
      if (m_wr && t == m_ack_cycle) begin
        if (m_addr < 7'd5) begin
          if (SHADOW) m_shd[m_addr] = m_data;
          else        m_out[m_addr] = m_data;
        end
        m_wr = 1'b0;
      end
      exp_a = (t == m_ack_cycle) && m_ack_a;
      exp_b = (t == m_ack_cycle) && !m_ack_a;
      exp_e = (t == m_ack_cycle) && m_err;
      check("rand", {a_ack, b_ack, err_addr, regs_now()},
            {exp_a, exp_b, exp_e, m_out[0], m_out[1], m_out[2], m_out[3], m_out[4]});

      if (a_req && exp_a) a_req = 1'b0;
      else if (!a_req && $urandom_range(0, 2) == 0) begin
        a_req = 1'b1; a_addr = 7'($urandom_range(0, 7)); a_data = 8'($urandom);
      end
      if (b_req && exp_b) b_req = 1'b0;
      else if (!b_req && $urandom_range(0, 2) == 0) begin
        b_req = 1'b1; b_addr = 7'($urandom_range(0, 7)); b_data = 8'($urandom);
      end
      commit = ($urandom_range(0, 5) == 0);

      if (t >= m_next_idle && (a_req || b_req)) begin
        win_a       = a_req && (!b_req || m_a_next);
        m_a_next    = !win_a;
        m_ack_a     = win_a;
        m_addr      = win_a ? a_addr : b_addr;
        m_data      = win_a ? a_data : b_data;
        m_err       = (m_addr >= 7'd5);
        m_wr        = 1'b1;
        m_ack_cycle = t + 2;
        m_next_idle = t + 3;
      end
      prev_commit = commit;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_bank_arbiter.md
REG_BANK_ARBITER -- requirements
Module: reg_bank_arbiter

Interface
REQ-001 SHALL have parameter DUTY_RST, default 8'h00: reset value of pwm_duty_cycle (and of its shadow when SHADOW_COMMIT_EN is defined).
REQ-002 SHALL have parameter PRIO_A_FIRST, default 1: reset value of the round-robin pointer; 1 = A wins the first tie, 0 = B wins the first tie.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have ports a_req (input, 1), a_addr (input, 7), a_data (input, 8) and a_ack (output, 1): requester A, the SPI frame decoder write port.
REQ-006 SHALL have ports b_req (input, 1), b_addr (input, 7), b_data (input, 8) and b_ack (output, 1): requester B, the on-chip sequencer write port.
REQ-007 SHALL have port commit, input, 1 bit: PWM-period-boundary strobe.
REQ-008 SHALL have outputs en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8 and pwm_duty_cycle, each 8 bits: the configuration register bank.
REQ-009 SHALL have port err_addr, output, 1 bit: pulse marking a write to an unmapped address.

Function
REQ-010 Address map SHALL be: 0 en_reg_out_7_0, 1 en_reg_out_15_8, 2 en_reg_pwm_7_0, 3 en_reg_pwm_15_8, 4 pwm_duty_cycle; addresses 5-127 are unmapped.
REQ-011 Requester protocol SHALL be:
- requester holds req high, with addr/data stable, until it sees ack;
- requester drops req on the cycle after ack;
- a req still high in IDLE is treated as a new request.
REQ-012 FSM states SHALL be IDLE, GRANT_A, GRANT_B and ACK.
REQ-013 FSM transitions SHALL be:
- IDLE to GRANT_x when any req is high;
- GRANT_x to ACK unconditionally;
- ACK to IDLE unconditionally.
REQ-014 On leaving IDLE for GRANT_x, the block SHALL latch the winner's addr/data.
REQ-015 Timing SHALL be: req sampled in IDLE at cycle N; register written at the end of cycle N+1; new value visible and x_ack high during cycle N+2.
REQ-016 x_ack SHALL be a one-cycle pulse; the two acks SHALL never both be high.
REQ-017 Throughput SHALL be at most one write per 3 cycles.
REQ-018 When both reqs are high in IDLE, the requester not granted last SHALL win; the pointer SHALL update on every grant.
REQ-019 When only one req is high, that requester SHALL be granted regardless of the pointer.
REQ-020 A loser holding req SHALL be granted on the next IDLE cycle; maximum wait is 3 cycles.
REQ-021 A write to an unmapped address SHALL change no register, SHALL still ack, and SHALL pulse err_addr in the ack cycle.
REQ-022 A req dropped before ack (protocol violation) SHALL not abort an in-flight grant; the latched write completes and is acked.
REQ-023 An unchanged write (same value) SHALL still ack normally.

Reset
REQ-024 rst high at a clock edge SHALL force, on the next cycle:
- FSM to IDLE;
- a_ack, b_ack and err_addr to 0;
- en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0 and en_reg_pwm_15_8 to 8'h00;
- pwm_duty_cycle to DUTY_RST;
- pointer to PRIO_A_FIRST.
REQ-025 Reset asserted during GRANT_x or ACK SHALL discard the write and issue no ack.
REQ-026 req inputs SHALL be ignored while rst is high.

Configuration
REQ-027 Macro SHADOW_COMMIT_EN SHALL select between immediate and committed writes.
REQ-028 With SHADOW_COMMIT_EN defined:
- writes go to five shadow registers;
- on a commit-high cycle, all five outputs load their shadows at once (visible next cycle);
- ack timing is unchanged;
- a shadow write and a commit in the same cycle: outputs take the pre-write shadow value, and the new value applies at the next commit.
REQ-029 Without SHADOW_COMMIT_EN, writes go directly to the outputs per REQ-015, and commit is present but ignored.

Verification
REQ-030 Bench SHALL cover single write: a_req, addr 4, data 8'h80 at cycle N -> pwm_duty_cycle = 8'h80 and a_ack = 1 at N+2; b_ack stays 0.
REQ-031 Bench SHALL cover a tie: a_req and b_req both high after reset (PRIO_A_FIRST = 1), A addr 0 data 8'h0F, B addr 0 data 8'hF0 -> A acked at N+2, B acked at N+5, final en_reg_out_7_0 = 8'hF0.
REQ-032 Bench SHALL cover unmapped address: b_req, addr 7, data 8'hFF -> b_ack and err_addr both high at N+2; all five registers unchanged.
REQ-033 Bench SHALL cover reset mid-operation: rst pulsed during GRANT_A of a write of 8'h55 to addr 2 -> no a_ack; en_reg_pwm_7_0 = 8'h00; FSM in IDLE.
REQ-034 Bench SHALL cover commit (SHADOW_COMMIT_EN defined): write 8'h33 to addr 1, then commit at N+4 -> en_reg_out_15_8 is 8'h00 until N+4 and 8'h33 from N+5.
REQ-035 Bench SHALL cover commit without the macro: same stimulus as REQ-034 -> en_reg_out_15_8 = 8'h33 from N+2.
